// File: rtl/noc_input_port_if.sv
// Flit-side handshake and crossbar-side request/grant signals of one router input port.
// The port drives the slave modport; the upstream link and arbiters sit on the master side.
interface noc_input_port_if;
    logic [3:0] flit_in;
    logic       flit_valid_in;
    logic       flit_ready_in;
    logic [4:0] request;
    logic [4:0] grant_vec;
    logic [3:0] flit_out;
    logic       flit_out_valid;

    modport master (
        output flit_in, flit_valid_in, grant_vec,
        input  flit_ready_in, request, flit_out, flit_out_valid
    );

    modport slave (
        input  flit_in, flit_valid_in, grant_vec,
        output flit_ready_in, request, flit_out, flit_out_valid
    );
endinterface

// File: rtl/noc_input_port.sv
// NoC router input port: flit FIFO, XY route computation on the buffered header,
// and a request/grant FSM that streams one whole packet per grant.
module noc_input_port #(
    parameter logic [1:0]  MY_X             = 2'd1,
    parameter logic [1:0]  MY_Y             = 2'd1,
    parameter int unsigned FLITS_PER_PACKET = 8,
    parameter int unsigned FIFO_DEPTH       = 16
) (
    input  logic            clk,
    input  logic            reset,
    noc_input_port_if.slave port_if
);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned FLIT_W = (FLITS_PER_PACKET > 1) ? $clog2(FLITS_PER_PACKET) : 1;
    localparam int unsigned PKT_W  = $clog2(FIFO_DEPTH / FLITS_PER_PACKET + 1);

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
    localparam logic [FLIT_W-1:0] FLIT_LAST = FLIT_W'(FLITS_PER_PACKET - 1);

    localparam logic [4:0] PORT_LOCAL = 5'b10000;
    localparam logic [4:0] PORT_NORTH = 5'b01000;
    localparam logic [4:0] PORT_SOUTH = 5'b00100;
    localparam logic [4:0] PORT_EAST  = 5'b00010;
    localparam logic [4:0] PORT_WEST  = 5'b00001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SEND    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PKT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [FLIT_W-1:0] flit_cnt_q, flit_cnt_d;
    logic [FLIT_W-1:0] send_cnt_q, send_cnt_d;
    logic [4:0]        route_q, route_d;
    logic [4:0]        request_q, request_d;
    logic [3:0]        flit_out_q, flit_out_d;
    logic              flit_out_valid_q, flit_out_valid_d;

    logic       ready;
    logic       push;
    logic       pop;
    logic       pkt_done;
    logic       pkt_start;
    logic [3:0] head_flit;
    logic [4:0] head_route;

    assign ready     = !reset && (count_q < CNT_FULL);
    assign push      = port_if.flit_valid_in && ready;
    assign pkt_done  = push && (flit_cnt_q == FLIT_LAST);
    assign pkt_start = (state_q == REQUEST) && |(port_if.grant_vec & route_q);
    assign head_flit = mem_q[rd_ptr_q];

    // The FIFO head is always a header whenever a route is latched, since only whole packets leave.
    always_comb begin
        head_route = PORT_LOCAL;
        if (head_flit[3:2] > MY_X) begin
            head_route = PORT_EAST;
        end else if (head_flit[3:2] < MY_X) begin
            head_route = PORT_WEST;
        end else if (head_flit[1:0] > MY_Y) begin
            head_route = PORT_NORTH;
        end else if (head_flit[1:0] < MY_Y) begin
            head_route = PORT_SOUTH;
        end
    end

    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    always_comb begin
        state_d          = state_q;
        route_d          = route_q;
        request_d        = request_q;
        send_cnt_d       = send_cnt_q;
        flit_out_d       = flit_out_q;
        flit_out_valid_d = flit_out_valid_q;
        pop              = 1'b0;

        case (state_q)
            IDLE: begin
                if (pkt_cnt_q != '0) begin
                    state_d   = REQUEST;
                    route_d   = head_route;
                    request_d = head_route;
                end
            end
            REQUEST: begin
                if (pkt_start) begin
                    state_d          = SEND;
                    request_d        = '0;
                    pop              = 1'b1;
                    send_cnt_d       = '0;
                    flit_out_d       = head_flit;
                    flit_out_valid_d = 1'b1;
                end
            end
            SEND: begin
                if (send_cnt_q == FLIT_LAST) begin
                    flit_out_d       = '0;
                    flit_out_valid_d = 1'b0;
                    if (pkt_cnt_q != '0) begin
                        state_d   = REQUEST;
                        route_d   = head_route;
                        request_d = head_route;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    pop        = 1'b1;
                    send_cnt_d = send_cnt_q + 1'b1;
                    flit_out_d = head_flit;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end

        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end

        flit_cnt_d = flit_cnt_q;
        if (push) begin
            flit_cnt_d = (flit_cnt_q == FLIT_LAST) ? '0 : flit_cnt_q + 1'b1;
        end

        pkt_cnt_d = pkt_cnt_q;
        if (pkt_done && !pkt_start) begin
            pkt_cnt_d = pkt_cnt_q + 1'b1;
        end else if (pkt_start && !pkt_done) begin
            pkt_cnt_d = pkt_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= IDLE;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            pkt_cnt_q        <= '0;
            flit_cnt_q       <= '0;
            send_cnt_q       <= '0;
            route_q          <= '0;
            request_q        <= '0;
            flit_out_q       <= '0;
            flit_out_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            pkt_cnt_q        <= pkt_cnt_d;
            flit_cnt_q       <= flit_cnt_d;
            send_cnt_q       <= send_cnt_d;
            route_q          <= route_d;
            request_q        <= request_d;
            flit_out_q       <= flit_out_d;
            flit_out_valid_q <= flit_out_valid_d;
        end
    end

    // NOTE: the flit storage has no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= port_if.flit_in;
        end
    end

    assign port_if.flit_ready_in  = ready;
    assign port_if.request        = request_q;
    assign port_if.flit_out       = flit_out_q;
    assign port_if.flit_out_valid = flit_out_valid_q;

endmodule

// File: tb/tb_noc_input_port.sv
// Self-checking bench for noc_input_port: a queue-based packet model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic, grants and resets.
module tb_noc_input_port;
    localparam int DEPTH = 16;
    localparam int FPP   = 8;
    localparam int RX    = 1;
    localparam int RY    = 1;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    noc_input_port_if bus ();

    noc_input_port #(
        .MY_X             (2'd1),
        .MY_Y             (2'd1),
        .FLITS_PER_PACKET (FPP),
        .FIFO_DEPTH       (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .port_if (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: buffered flits, packets waiting for a grant, and the packet being streamed.
    logic [3:0] m_q[$];
    int         m_partial;
    int         m_pkts;
    int         m_shown;
    logic [4:0] m_req;
    logic [3:0] m_flit;
    logic       m_valid;
    logic       m_live = 1'b0;
    logic       m_acc;

    function automatic logic [4:0] route_of(input logic [3:0] h);
        int dx;
        int dy;
        dx = int'(h) / 4;
        dy = int'(h) % 4;
        if (dx > RX) return 5'b00010;
        if (dx < RX) return 5'b00001;
        if (dy > RY) return 5'b01000;
        if (dy < RY) return 5'b00100;
        return 5'b10000;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                m_q.delete();
                m_partial = 0;
                m_pkts    = 0;
                m_shown   = 0;
                m_req     = '0;
                m_flit    = '0;
                m_valid   = 1'b0;
                m_live    = 1'b1;
            end else if (m_live) begin
                m_acc = bus.flit_valid_in && (m_q.size() < DEPTH);
                if (m_req != 0 && (bus.grant_vec & m_req) != 0) begin
                    m_req   = '0;
                    m_pkts  = m_pkts - 1;
                    m_flit  = m_q.pop_front();
                    m_valid = 1'b1;
                    m_shown = 1;
                end else if (m_valid) begin
                    if (m_shown < FPP) begin
                        m_flit  = m_q.pop_front();
                        m_shown = m_shown + 1;
                    end else begin
                        m_valid = 1'b0;
                        m_flit  = '0;
                        m_shown = 0;
                        if (m_pkts > 0) m_req = route_of(m_q[0]);
                    end
                end else if (m_req == 0 && m_pkts > 0) begin
                    m_req = route_of(m_q[0]);
                end
                if (m_acc) begin
                    m_q.push_back(bus.flit_in);
                    m_partial = m_partial + 1;
                    if (m_partial == FPP) begin
                        m_partial = 0;
                        m_pkts    = m_pkts + 1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("model_ready", bus.flit_ready_in, (!reset && m_q.size() < DEPTH));
                check("model_request", bus.request, m_req);
                check("model_flit_out", bus.flit_out, m_flit);
                check("model_valid", bus.flit_out_valid, m_valid);
            end
        end
    end

    task automatic step(input logic v, input logic [3:0] f, input logic [4:0] g, input logic r = 1'b0);
        bus.flit_valid_in = v;
        bus.flit_in       = f;
        bus.grant_vec     = g;
        reset             = r;
        @(negedge clk);
        #1;
    endtask

    task automatic push_pkt(input logic [3:0] hdr);
        for (int i = 0; i < FPP; i++) begin
            step(1'b1, (i == 0) ? hdr : 4'(i), 5'b0);
        end
    endtask

    task automatic grant_drain(input logic [4:0] g);
        step(1'b0, 4'h0, g);
        repeat (FPP) step(1'b0, 4'h0, 5'b0);
    endtask

    logic [3:0] s1_exp [8] = '{4'h9, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7};
    logic [3:0] s2_hdr [4] = '{4'b0101, 4'b0100, 4'b0001, 4'b0110};
    logic [4:0] s2_req [4] = '{5'b10000, 5'b00100, 5'b00001, 5'b01000};

    initial begin
        bus.flit_in       = '0;
        bus.flit_valid_in = 1'b0;
        bus.grant_vec     = '0;
        reset             = 1'b1;

        // Reset state
        step(1'b0, 4'h0, 5'b0, 1'b1);
        step(1'b0, 4'h0, 5'b0, 1'b1);
        check("rst_ready", bus.flit_ready_in, 1'b0);
        check("rst_request", bus.request, 5'b0);
        check("rst_valid", bus.flit_out_valid, 1'b0);
        check("rst_flit", bus.flit_out, 4'h0);
        step(1'b0, 4'h0, 5'b0);
        check("rst_ready_after", bus.flit_ready_in, 1'b1);

        // Single east-bound packet
        push_pkt(4'b1001);
        check("s1_req_early", bus.request, 5'b0);
        step(1'b0, 4'h0, 5'b0);
        check("s1_req", bus.request, 5'b00010);
        repeat (3) step(1'b0, 4'h0, 5'b0);
        check("s1_req_hold", bus.request, 5'b00010);
        step(1'b0, 4'h0, 5'b00010);
        for (int i = 0; i < 8; i++) begin
            if (i > 0) step(1'b0, 4'h0, 5'b0);
            check("s1_flit", bus.flit_out, s1_exp[i]);
            check("s1_valid", bus.flit_out_valid, 1'b1);
        end
        step(1'b0, 4'h0, 5'b0);
        check("s1_end_valid", bus.flit_out_valid, 1'b0);
        check("s1_end_req", bus.request, 5'b0);
        check("s1_end_flit", bus.flit_out, 4'h0);

        // Routing of each direction
        for (int k = 0; k < 4; k++) begin
            push_pkt(s2_hdr[k]);
            step(1'b0, 4'h0, 5'b0);
            check("s2_route", bus.request, s2_req[k]);
            grant_drain(s2_req[k]);
        end

        // Fill to capacity and refuse the 17th flit until a packet leaves
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i % 8 == 0) ? 4'b1001 : 4'(i), 5'b0);
        end
        check("s3_full_ready", bus.flit_ready_in, 1'b0);
        step(1'b1, 4'b0110, 5'b0);
        check("s3_still_full", bus.flit_ready_in, 1'b0);
        step(1'b1, 4'b0110, 5'b00010);
        check("s3_ready_after_pop", bus.flit_ready_in, 1'b1);
        step(1'b1, 4'b0110, 5'b0);
        repeat (6) step(1'b0, 4'h0, 5'b0);
        step(1'b0, 4'h0, 5'b0);
        check("s3_second_req", bus.request, 5'b00010);
        grant_drain(5'b00010);
        for (int i = 1; i < FPP; i++) step(1'b1, 4'(i), 5'b0);
        step(1'b0, 4'h0, 5'b0);
        check("s3_third_req", bus.request, 5'b01000);
        grant_drain(5'b01000);

        // Grants on other ports are ignored
        push_pkt(4'b1001);
        step(1'b0, 4'h0, 5'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 4'h0, 5'b00100);
            check("s4_no_send", bus.flit_out_valid, 1'b0);
        end
        check("s4_req_hold", bus.request, 5'b00010);
        grant_drain(5'b00010);

        // Back-to-back packets: next request right after the 8th flit
        push_pkt(4'b1001);
        push_pkt(4'b0001);
        check("s5_first_req", bus.request, 5'b00010);
        step(1'b0, 4'h0, 5'b00010);
        repeat (7) step(1'b0, 4'h0, 5'b0);
        check("s5_last_flit", bus.flit_out, 4'h7);
        step(1'b0, 4'h0, 5'b0);
        check("s5_next_req", bus.request, 5'b00001);
        check("s5_gap_valid", bus.flit_out_valid, 1'b0);
        grant_drain(5'b00001);

        // Reset during SEND at the 4th flit
        push_pkt(4'b0110);
        step(1'b0, 4'h0, 5'b0);
        step(1'b0, 4'h0, 5'b01000);
        repeat (3) step(1'b0, 4'h0, 5'b0);
        check("s6_fourth_flit", bus.flit_out, 4'h3);
        step(1'b0, 4'h0, 5'b0, 1'b1);
        check("s6_rst_valid", bus.flit_out_valid, 1'b0);
        check("s6_rst_req", bus.request, 5'b0);
        check("s6_rst_ready", bus.flit_ready_in, 1'b0);
        step(1'b0, 4'h0, 5'b0);
        check("s6_ready_release", bus.flit_ready_in, 1'b1);
        repeat (5) step(1'b0, 4'h0, 5'b0);
        check("s6_no_stale_pkt", bus.request, 5'b0);

        // Reset mid-packet on the input side: next accepted flit is a header
        for (int i = 0; i < 3; i++) step(1'b1, 4'hA, 5'b0);
        step(1'b0, 4'h0, 5'b0, 1'b1);
        step(1'b0, 4'h0, 5'b0);
        push_pkt(4'b0001);
        step(1'b0, 4'h0, 5'b0);
        check("s6_new_header", bus.request, 5'b00001);
        grant_drain(5'b00001);

        // Randomized traffic, grants and occasional resets
        for (int c = 0; c < 3000; c++) begin
            step(($urandom_range(0, 9) < 7), 4'($urandom), 5'($urandom),
                 ($urandom_range(0, 299) == 0));
        end
        repeat (4) step(1'b0, 4'h0, 5'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
